// File: rtl/mips_multicycle_core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_multicycle_core_pkg
//  Description : Opcode, funct, ALU-code and FSM state constants for the
//                multicycle MIPS core, plus small decode helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package mips_multicycle_core_pkg;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    localparam logic [5:0] c_FN_ADD = 6'b100000;
    localparam logic [5:0] c_FN_SUB = 6'b100010;
    localparam logic [5:0] c_FN_AND = 6'b100100;
    localparam logic [5:0] c_FN_OR  = 6'b100101;
    localparam logic [5:0] c_FN_SLT = 6'b101010;

    localparam logic [2:0] c_ALU_AND = 3'b000;
    localparam logic [2:0] c_ALU_OR  = 3'b001;
    localparam logic [2:0] c_ALU_ADD = 3'b010;
    localparam logic [2:0] c_ALU_SUB = 3'b110;
    localparam logic [2:0] c_ALU_SLT = 3'b111;

    typedef logic [2:0] state_t;

    localparam state_t c_ST_FETCH  = 3'd0;
    localparam state_t c_ST_LOADIR = 3'd1;
    localparam state_t c_ST_EXEC   = 3'd2;
    localparam state_t c_ST_MEM    = 3'd3;
    localparam state_t c_ST_MEMRD  = 3'd4;
    localparam state_t c_ST_WB     = 3'd5;
    localparam state_t c_ST_HALT   = 3'd6;

    function automatic logic f_is_legal(input logic [5:0] op, input logic [5:0] funct);
        logic legal;
        legal = 1'b0;
        case (op)
            c_OP_RTYPE: legal = (funct == c_FN_ADD) || (funct == c_FN_SUB) ||
                                (funct == c_FN_AND) || (funct == c_FN_OR)  ||
                                (funct == c_FN_SLT);
            c_OP_ADDI, c_OP_LW, c_OP_SW, c_OP_BEQ, c_OP_J: legal = 1'b1;
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Address arithmetic for addi/lw/sw uses add; beq compares by subtracting.
    function automatic logic [2:0] f_alu_ctrl(input logic [5:0] op, input logic [5:0] funct);
        logic [2:0] ctrl;
        ctrl = c_ALU_ADD;
        if (op == c_OP_BEQ) begin
            ctrl = c_ALU_SUB;
        end else if (op == c_OP_RTYPE) begin
            case (funct)
                c_FN_SUB: ctrl = c_ALU_SUB;
                c_FN_AND: ctrl = c_ALU_AND;
                c_FN_OR:  ctrl = c_ALU_OR;
                c_FN_SLT: ctrl = c_ALU_SLT;
                default:  ctrl = c_ALU_ADD;
            endcase
        end
        return ctrl;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_multicycle_core_alu.sv
`default_nettype none
// ============================================================================
//  Module      : mips_multicycle_core_alu
//  Description : Combinational ALU (and/or/add/sub/signed slt) with zero flag.
//  Revision    : 1.0  initial release
// ============================================================================
module mips_multicycle_core_alu
    import mips_multicycle_core_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [2:0]        i_ctrl,
    output logic [DATA_W-1:0] o_y,
    output logic              o_zero
);

    always_comb begin
        o_y = '0;
        case (i_ctrl)
            c_ALU_AND: o_y = i_a & i_b;
            c_ALU_OR:  o_y = i_a | i_b;
            c_ALU_ADD: o_y = i_a + i_b;
            c_ALU_SUB: o_y = i_a - i_b;
            c_ALU_SLT: o_y = {{(DATA_W-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            default:   o_y = '0;
        endcase
    end

    assign o_zero = (o_y == '0);

endmodule
`default_nettype wire

// File: rtl/mips_multicycle_core.sv
`default_nettype none
// ============================================================================
//  Module      : mips_multicycle_core
//  Description : Enable-gated multicycle MIPS subset core for synchronous
//                ROM/RAM, with debug register read and sticky illegal halt.
//  Revision    : 1.0  initial release
// ============================================================================
module mips_multicycle_core
    import mips_multicycle_core_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int PC_W   = 8,
    parameter int RA_W   = 3
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              en,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic              dmem_we,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic [RA_W-1:0]   dbg_ra,
    output logic [DATA_W-1:0] dbg_rd,
    output logic [PC_W-1:0]   pc_o,
    output logic [2:0]        state_o,
    output logic              instr_done,
    output logic              halted
);

    localparam int c_NREG = 2**RA_W;

    state_t            r_state;
    state_t            w_next;
    logic [PC_W-1:0]   r_pc;
    logic [31:0]       r_ir;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_aluout;
    logic [DATA_W-1:0] r_rf [c_NREG];

    logic [5:0]        w_op;
    logic [5:0]        w_funct;
    logic [RA_W-1:0]   w_rs;
    logic [RA_W-1:0]   w_rt;
    logic [RA_W-1:0]   w_rd;
    logic [31:0]       w_imm32;
    logic [DATA_W-1:0] w_imm;
    logic [DATA_W-1:0] w_rs_val;
    logic [DATA_W-1:0] w_rt_val;
    logic [DATA_W-1:0] w_alu_b;
    logic [DATA_W-1:0] w_alu_y;
    logic              w_alu_zero;
    logic              w_is_rtype;
    logic              w_is_beq;
    logic              w_is_j;
    logic              w_is_lw;
    logic              w_is_sw;
    logic [PC_W-1:0]   w_pc_inc;
    logic [PC_W-1:0]   w_pc_br;
    logic [PC_W-1:0]   w_pc_next;
    logic              w_pc_we;
    logic              w_ir_load;
    logic              w_exec_load;
    logic              w_rf_we;
    logic [RA_W-1:0]   w_rf_wa;
    logic [DATA_W-1:0] w_rf_wd;
    logic              w_mem_we;
    logic              w_retire;
    logic              w_unused;

    assign w_op     = r_ir[31:26];
    assign w_funct  = r_ir[5:0];
    assign w_rs     = r_ir[21 +: RA_W];
    assign w_rt     = r_ir[16 +: RA_W];
    assign w_rd     = r_ir[11 +: RA_W];
    assign w_imm32  = {{16{r_ir[15]}}, r_ir[15:0]};
    assign w_imm    = w_imm32[DATA_W-1:0];
    assign w_unused = ^{r_ir, w_imm32};

    assign w_is_rtype = (w_op == c_OP_RTYPE);
    assign w_is_beq   = (w_op == c_OP_BEQ);
    assign w_is_j     = (w_op == c_OP_J);
    assign w_is_lw    = (w_op == c_OP_LW);
    assign w_is_sw    = (w_op == c_OP_SW);

    assign w_rs_val = r_rf[w_rs];
    assign w_rt_val = r_rf[w_rt];
    assign w_alu_b  = (w_is_rtype || w_is_beq) ? w_rt_val : w_imm;

    assign w_pc_inc = r_pc + PC_W'(1);
    assign w_pc_br  = w_pc_inc + w_imm32[PC_W-1:0];

    mips_multicycle_core_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .i_a    (w_rs_val),
        .i_b    (w_alu_b),
        .i_ctrl (f_alu_ctrl(w_op, w_funct)),
        .o_y    (w_alu_y),
        .o_zero (w_alu_zero)
    );

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            r_state <= c_ST_FETCH;
        end else if (en) begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_pc_next   = r_pc;
        w_pc_we     = 1'b0;
        w_ir_load   = 1'b0;
        w_exec_load = 1'b0;
        w_rf_we     = 1'b0;
        w_rf_wa     = w_rt;
        w_rf_wd     = r_aluout;
        w_mem_we    = 1'b0;
        w_retire    = 1'b0;
        case (r_state)
            c_ST_FETCH: begin
                w_next = c_ST_LOADIR;
            end
            c_ST_LOADIR: begin
                w_ir_load = 1'b1;
                w_next    = f_is_legal(imem_rdata[31:26], imem_rdata[5:0]) ? c_ST_EXEC : c_ST_HALT;
            end
            c_ST_EXEC: begin
                w_exec_load = 1'b1;
                if (w_is_beq) begin
                    w_pc_we   = 1'b1;
                    w_pc_next = w_alu_zero ? w_pc_br : w_pc_inc;
                    w_retire  = 1'b1;
                    w_next    = c_ST_FETCH;
                end else if (w_is_j) begin
                    w_pc_we   = 1'b1;
                    w_pc_next = r_ir[PC_W-1:0];
                    w_retire  = 1'b1;
                    w_next    = c_ST_FETCH;
                end else if (w_is_lw || w_is_sw) begin
                    w_next = c_ST_MEM;
                end else begin
                    w_next = c_ST_WB;
                end
            end
            c_ST_MEM: begin
                if (w_is_sw) begin
                    w_mem_we  = 1'b1;
                    w_pc_we   = 1'b1;
                    w_pc_next = w_pc_inc;
                    w_retire  = 1'b1;
                    w_next    = c_ST_FETCH;
                end else begin
                    w_next = c_ST_MEMRD;
                end
            end
            c_ST_MEMRD: begin
                w_rf_we   = 1'b1;
                w_rf_wa   = w_rt;
                w_rf_wd   = dmem_rdata;
                w_pc_we   = 1'b1;
                w_pc_next = w_pc_inc;
                w_retire  = 1'b1;
                w_next    = c_ST_FETCH;
            end
            c_ST_WB: begin
                w_rf_we   = 1'b1;
                w_rf_wa   = w_is_rtype ? w_rd : w_rt;
                w_rf_wd   = r_aluout;
                w_pc_we   = 1'b1;
                w_pc_next = w_pc_inc;
                w_retire  = 1'b1;
                w_next    = c_ST_FETCH;
            end
            c_ST_HALT: begin
                w_next = c_ST_HALT;
            end
            default: begin
                w_next = c_ST_FETCH;
            end
        endcase
    end

    // r0 is never written, so it reads as zero without an output mux.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            r_pc     <= '0;
            r_ir     <= '0;
            r_b      <= '0;
            r_aluout <= '0;
            for (int i = 0; i < c_NREG; i++) begin
                r_rf[i] <= '0;
            end
        end else if (en) begin
            if (w_pc_we) begin
                r_pc <= w_pc_next;
            end
            if (w_ir_load) begin
                r_ir <= imem_rdata;
            end
            if (w_exec_load) begin
                r_b      <= w_rt_val;
                r_aluout <= w_alu_y;
            end
            if (w_rf_we && (w_rf_wa != '0)) begin
                r_rf[w_rf_wa] <= w_rf_wd;
            end
        end
    end

    assign imem_addr  = r_pc;
    assign pc_o       = r_pc;
    assign dmem_addr  = r_aluout;
    assign dmem_wdata = r_b;
    assign dmem_we    = w_mem_we & en & iRST_N;
    assign instr_done = w_retire & en & iRST_N;
    assign dbg_rd     = r_rf[dbg_ra];
    assign state_o    = r_state;
    assign halted     = (r_state == c_ST_HALT);

endmodule
`default_nettype wire
